// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bus for multicycle_ctrl.
// The controller takes the master modport. The datapath, or a bench standing in
// for it, takes the slave modport.
interface multicycle_ctrl_if #(
    parameter int ALUOP_W = 4
);
    // Instruction fields and status flags into the controller
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               md_done;

    // Control outputs from the controller
    logic               pc_write;
    logic               ir_write;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               s_num_write;
    logic               s_b;
    logic               s_wb;
    logic               md_start;
    logic               trap;
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         s_ext;
    logic [2:0]         state;

    modport master (
        input  op, funct, zero, md_done,
        output pc_write, ir_write, reg_write, mem_read, mem_write,
               s_num_write, s_b, s_wb, md_start, trap, aluop, s_ext, state
    );

    modport slave (
        output op, funct, zero, md_done,
        input  pc_write, ir_write, reg_write, mem_read, mem_write,
               s_num_write, s_b, s_wb, md_start, trap, aluop, s_ext, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM control unit for a small MIPS-like multicycle datapath.
//
// Instruction flow:
//   FETCH -> DECODE -> EXEC -> {MEM, WB, MD_WAIT, FETCH}
//
// TRAP state:
//   - Entered on an unknown opcode or on a mult/div timeout.
//   - Sticky until reset.
//
// ALU opcode encodings (zero-extended to ALUOP_W):
//   ADDU = 0001, SUBU = 0011, AND = 0100, OR = 0101, LUI = 1111.
//   ADDU/SUBU/AND/OR match the low four bits of the matching R-type funct.
//
// s_ext encodings:
//   00 = zero-extend, 01 = sign-extend.
//
// Optional feature, enabled by defining MULTDIV_EN:
//   - MULT and DIV start the external unit and wait in MD_WAIT with a timeout.
//   - Without the macro, both functs trap from DECODE.
module multicycle_ctrl #(
    parameter int ALUOP_W    = 4,
    parameter int MD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_MD_WAIT = 3'd5;
    localparam logic [2:0] S_TRAP    = 3'd6;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_J       = 6'b000010;

    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    localparam logic [3:0] ALU_ADDU = 4'b0001;
    localparam logic [3:0] ALU_SUBU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;

    // Last MD_WAIT count value before the wait is declared hung
    localparam logic [7:0] MD_LAST = 8'(MD_TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [5:0] op_q, funct_q;
    logic       op_legal;
    logic       is_md;

    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_DIV);
    endfunction

    function automatic logic [ALUOP_W-1:0] alu(input logic [3:0] code);
        return ALUOP_W'(code);
    endfunction

    // Judge the live opcode during DECODE; the latched copy is not valid yet
    always_comb begin
        case (bus.op)
            OP_SPECIAL: begin
`ifdef MULTDIV_EN
                op_legal = 1'b1;
`else
                op_legal = !is_md_funct(bus.funct);
`endif
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI,
            OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
            default:                    op_legal = 1'b0;
        endcase
    end

`ifdef MULTDIV_EN
    logic [7:0] md_cnt_q, md_cnt_d;

    assign is_md = (op_q == OP_SPECIAL) && is_md_funct(funct_q);

    // Count cycles spent in MD_WAIT; completion or any other state clears it
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        md_cnt_d = 8'd0;
        if ((state_q == S_MD_WAIT) && !bus.md_done) begin
            md_cnt_d = md_cnt_q + 8'd1;
        end
    end

    // Mult/div wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q <= 8'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end
`else
    logic [8:0] unused_md;

    assign is_md     = 1'b0;
    assign unused_md = {bus.md_done, MD_LAST};
`endif

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = op_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (op_q)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ, OP_J: state_d = S_FETCH;
                    default:      state_d = is_md ? S_MD_WAIT : S_WB;
                endcase
            end
            S_MEM: state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
            S_WB:  state_d = S_FETCH;
            S_MD_WAIT: begin
`ifdef MULTDIV_EN
                // Completion wins over a timeout that lands in the same cycle
                if (bus.md_done) begin
                    state_d = S_FETCH;
                end else if (md_cnt_q == MD_LAST) begin
                    state_d = S_TRAP;
                end
`else
                state_d = S_TRAP;
`endif
            end
            default: state_d = S_TRAP;
        endcase
    end

    // State register and the instruction-field latches loaded in DECODE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values regardless of block order.
            state_q <= S_FETCH;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q    <= bus.op;
                funct_q <= bus.funct;
            end
        end
    end

    // Control outputs, decoded from the state and the latched fields and forced idle during reset
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.s_num_write = 1'b0;
        bus.s_b         = 1'b0;
        bus.s_wb        = 1'b0;
        bus.md_start    = 1'b0;
        bus.trap        = 1'b0;
        bus.aluop       = '0;
        bus.s_ext       = EXT_ZERO;
        bus.state       = state_q;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    bus.aluop    = alu(ALU_ADDU);
                end
                S_DECODE, S_MD_WAIT: begin
                end
                S_EXEC: begin
                    case (op_q)
                        OP_SPECIAL: begin
                            bus.aluop       = ALUOP_W'(funct_q);
                            bus.s_num_write = 1'b1;
                            bus.md_start    = is_md;
                        end
                        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                            bus.aluop = alu(ALU_ADDU);
                            bus.s_ext = EXT_SIGN;
                            bus.s_b   = 1'b1;
                        end
                        OP_ANDI: begin
                            bus.aluop = alu(ALU_AND);
                            bus.s_b   = 1'b1;
                        end
                        OP_ORI: begin
                            bus.aluop = alu(ALU_OR);
                            bus.s_b   = 1'b1;
                        end
                        OP_LUI: begin
                            bus.aluop = alu(ALU_LUI);
                            bus.s_b   = 1'b1;
                        end
                        OP_BEQ: begin
                            // Subtract rs - rt so the datapath's zero flag reflects equality
                            bus.aluop    = alu(ALU_SUBU);
                            bus.pc_write = bus.zero;
                        end
                        default: bus.pc_write = 1'b1;
                    endcase
                end
                S_MEM: begin
                    bus.mem_read  = (op_q == OP_LW);
                    bus.mem_write = (op_q == OP_SW);
                end
                S_WB: begin
                    bus.reg_write = 1'b1;
                    bus.s_wb      = (op_q == OP_LW);
                end
                default: bus.trap = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// For each instruction, a reference model builds the expected cycle-by-cycle
// sequence from the instruction's class. Random instructions are then run
// against it, including random resets in the middle of an instruction.
module tb_multicycle_ctrl;

    localparam int ALUOP_W    = 4;
    localparam int MD_TIMEOUT = 64;

    localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3, ST_WB = 3'd4, ST_MD_WAIT = 3'd5, ST_TRAP = 3'd6;

    localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
    localparam logic [5:0] FN_MULT = 6'b011000, FN_DIV = 6'b011010;

    localparam logic [3:0] A_ADDU = 4'b0001, A_SUBU = 4'b0011, A_AND = 4'b0100;
    localparam logic [3:0] A_OR = 4'b0101, A_LUI = 4'b1111;

`ifdef MULTDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] state;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       s_num_write;
        logic       s_b;
        logic       s_wb;
        logic       md_start;
        logic       trap;
        logic [3:0] aluop;
        logic [1:0] s_ext;
    } outs_t;

    typedef struct {
        outs_t exp;
        logic  zero;
        logic  md_done;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    cyc_t plan[$];

    logic [5:0] known_ops [10] = '{OP_SPECIAL, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
                                   OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};

    multicycle_ctrl_if #(.ALUOP_W(ALUOP_W)) bus ();

    multicycle_ctrl #(.ALUOP_W(ALUOP_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic outs_t obs();
        outs_t o;
        o.state       = bus.state;
        o.pc_write    = bus.pc_write;
        o.ir_write    = bus.ir_write;
        o.reg_write   = bus.reg_write;
        o.mem_read    = bus.mem_read;
        o.mem_write   = bus.mem_write;
        o.s_num_write = bus.s_num_write;
        o.s_b         = bus.s_b;
        o.s_wb        = bus.s_wb;
        o.md_start    = bus.md_start;
        o.trap        = bus.trap;
        o.aluop       = bus.aluop;
        o.s_ext       = bus.s_ext;
        return o;
    endfunction

    // Fields that must all be zero while reset is held
    function automatic logic [9:0] rst_view();
        return {bus.state, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.md_start, bus.trap};
    endfunction

    function automatic outs_t blank(input logic [2:0] st);
        outs_t o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        return op inside {OP_SPECIAL, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
                          OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

    function automatic bit is_mult_div(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_DIV);
    endfunction

    task automatic push(input outs_t o, input logic z, input logic md);
        cyc_t c;
        c.exp     = o;
        c.zero    = z;
        c.md_done = md;
        plan.push_back(c);
    endtask

    // A trapped controller is observed for ten cycles before being reset
    task automatic add_trap();
        outs_t o;
        o = blank(ST_TRAP);
        o.trap = 1'b1;
        repeat (10) push(o, rbit(), rbit());
    endtask

    // Reference model: expected cycle sequence for one instruction.
    // For mult/div, md_wait is the number of MD_WAIT cycles before md_done.
    // A value of MD_TIMEOUT or more means md_done never arrives.
    task automatic make_plan(input logic [5:0] op, input logic [5:0] funct,
                             input logic zero, input int md_wait);
        outs_t o;
        plan.delete();
        o = blank(ST_FETCH);
        o.ir_write = 1'b1;
        o.pc_write = 1'b1;
        o.aluop    = A_ADDU;
        push(o, rbit(), rbit());
        push(blank(ST_DECODE), rbit(), rbit());
        if (!op_known(op) || (op == OP_SPECIAL && is_mult_div(funct) && !MD_EN)) begin
            add_trap();
            return;
        end
        o = blank(ST_EXEC);
        case (op)
            OP_SPECIAL: begin o.aluop = funct[3:0]; o.s_num_write = 1'b1; end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin o.aluop = A_ADDU; o.s_ext = 2'b01; o.s_b = 1'b1; end
            OP_ANDI:    begin o.aluop = A_AND; o.s_b = 1'b1; end
            OP_ORI:     begin o.aluop = A_OR;  o.s_b = 1'b1; end
            OP_LUI:     begin o.aluop = A_LUI; o.s_b = 1'b1; end
            OP_BEQ:     begin o.aluop = A_SUBU; o.pc_write = zero; end
            default:    o.pc_write = 1'b1;
        endcase
        if (op == OP_SPECIAL && is_mult_div(funct)) begin
            o.md_start = 1'b1;
            push(o, rbit(), rbit());
            if (md_wait >= MD_TIMEOUT) begin
                repeat (MD_TIMEOUT) push(blank(ST_MD_WAIT), rbit(), 1'b0);
                add_trap();
            end else begin
                repeat (md_wait) push(blank(ST_MD_WAIT), rbit(), 1'b0);
                push(blank(ST_MD_WAIT), rbit(), 1'b1);
            end
            return;
        end
        push(o, (op == OP_BEQ) ? zero : rbit(), rbit());
        if (op == OP_LW) begin
            o = blank(ST_MEM); o.mem_read = 1'b1; push(o, rbit(), rbit());
            o = blank(ST_WB);  o.reg_write = 1'b1; o.s_wb = 1'b1; push(o, rbit(), rbit());
        end else if (op == OP_SW) begin
            o = blank(ST_MEM); o.mem_write = 1'b1; push(o, rbit(), rbit());
        end else if (op != OP_BEQ && op != OP_J) begin
            o = blank(ST_WB);  o.reg_write = 1'b1; push(o, rbit(), rbit());
        end
    endtask

    // Hold reset across one rising edge, checking outputs, and release it well before the next edge
    task automatic apply_reset(input string name);
        rst = 1'b1;
        #1;
        check({name, " in rst"}, 32'(rst_view()), 32'd0);
        @(negedge clk);
        #1;
        check({name, " rst held"}, 32'(rst_view()), 32'd0);
        rst = 1'b0;
    endtask

    // Play the plan one cycle at a time; op/funct are scrambled once DECODE is past
    task automatic run_plan(input string name, input int abort_at);
        for (int i = 0; i < plan.size(); i++) begin
            if (i == abort_at) begin
                apply_reset({name, " abort"});
                return;
            end
            bus.zero    = plan[i].zero;
            bus.md_done = plan[i].md_done;
            if (i == 2) begin
                bus.op    = 6'($urandom);
                bus.funct = 6'($urandom);
            end
            #1;
            check($sformatf("%s c%0d", name, i), 32'(obs()), 32'(plan[i].exp));
            @(negedge clk);
        end
        if (plan[plan.size()-1].exp.state == ST_TRAP) apply_reset({name, " unstick"});
    endtask

    task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] funct,
                            input logic zero, input int md_wait, input int abort_at);
        bus.op    = op;
        bus.funct = funct;
        make_plan(op, funct, zero, md_wait);
        run_plan(name, abort_at);
    endtask

    initial begin
        bus.op      = 6'd0;
        bus.funct   = 6'd0;
        bus.zero    = 1'b0;
        bus.md_done = 1'b0;
        @(negedge clk);
        apply_reset("por");

        do_instr("addu",  OP_SPECIAL, 6'b100001, 1'b0, 0, -1);
        do_instr("lw",    OP_LW,      6'($urandom), 1'b0, 0, -1);
        do_instr("sw",    OP_SW,      6'($urandom), 1'b0, 0, -1);
        do_instr("beq1",  OP_BEQ,     6'($urandom), 1'b1, 0, -1);
        do_instr("beq0",  OP_BEQ,     6'($urandom), 1'b0, 0, -1);
        do_instr("j",     OP_J,       6'($urandom), 1'b0, 0, -1);
        do_instr("addi",  OP_ADDI,    6'($urandom), 1'b0, 0, -1);
        do_instr("andi",  OP_ANDI,    6'($urandom), 1'b0, 0, -1);
        do_instr("ori",   OP_ORI,     6'($urandom), 1'b0, 0, -1);
        do_instr("lui",   OP_LUI,     6'($urandom), 1'b0, 0, -1);
        do_instr("bad",   6'b111111,  6'($urandom), 1'b0, 0, -1);
        do_instr("badab", 6'b111111,  6'($urandom), 1'b0, 0, 6);
`ifdef MULTDIV_EN
        do_instr("mult5", OP_SPECIAL, FN_MULT, 1'b0, 5, -1);
        do_instr("div0",  OP_SPECIAL, FN_DIV,  1'b0, 0, -1);
        do_instr("mdlst", OP_SPECIAL, FN_MULT, 1'b0, MD_TIMEOUT - 1, -1);
        do_instr("mdto",  OP_SPECIAL, FN_DIV,  1'b0, MD_TIMEOUT, -1);
        do_instr("mdab",  OP_SPECIAL, FN_MULT, 1'b0, 8, 6);
`else
        do_instr("multx", OP_SPECIAL, FN_MULT, 1'b0, 0, -1);
        do_instr("divx",  OP_SPECIAL, FN_DIV,  1'b0, 0, -1);
`endif
        do_instr("lwab",  OP_LW, 6'($urandom), 1'b0, 0, 3);
        do_instr("swab",  OP_SW, 6'($urandom), 1'b0, 0, 3);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            logic [5:0] funct;
            int         sel;
            int         r;
            int         mdw;
            int         ab;
            sel   = $urandom_range(0, 11);
            funct = 6'($urandom);
            if (sel < 10) begin
                op = known_ops[sel];
            end else if (sel == 10) begin
                do op = 6'($urandom); while (op_known(op));
            end else begin
                op    = OP_SPECIAL;
                funct = rbit() ? FN_MULT : FN_DIV;
            end
            r   = $urandom_range(0, 9);
            mdw = (r < 8) ? r : ((r == 8) ? MD_TIMEOUT - 1 : MD_TIMEOUT);
            ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : -1;
            do_instr($sformatf("rnd%0d", n), op, funct, rbit(), mdw, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Backstop so a broken design can never hang the run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ALUOP_W, default 4: ALU opcode width (min 4).
REQ-002 SHALL have parameter MD_TIMEOUT, default 64: max MD_WAIT cycles before trap (1..255).
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports op  in  6  and  funct  in  6: instruction fields, valid from DECODE onward.
REQ-006 SHALL have port zero  in  1: ALU zero flag for BEQ.
REQ-007 SHALL have port md_done  in  1: multiply/divide unit completion.
REQ-008 SHALL have outputs pc_write, ir_write, reg_write, mem_read, mem_write, s_num_write, s_b, s_wb, md_start, trap (1 bit each).
REQ-009 SHALL have outputs aluop  out  ALUOP_W;  s_ext  out  2;  state  out  3.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MD_WAIT=5, TRAP=6; value 7 unreachable, decodes to TRAP.
REQ-011 SHALL, in FETCH, assert ir_write=1, pc_write=1, aluop=ADDU; next DECODE.
REQ-012 SHALL, in DECODE, latch op/funct into internal registers; all later decode uses latched copies.
REQ-013 SHALL recognise op SPECIAL 000000, ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, J 000010; others -> TRAP from DECODE.
REQ-014 SHALL, in EXEC: R-type aluop=funct zero-extended/truncated to ALUOP_W, s_num_write=1, s_b=0; I-type ALU ops aluop/s_ext as ADDI/ADDIU=ADDU,sign; ANDI=AND,zero; ORI=OR,zero; LUI=LUI,zero; s_b=1, s_num_write=0.
REQ-015 SHALL route EXEC -> WB for ALU ops, -> MEM for LW/SW (aluop=ADDU, s_ext=sign, s_b=1), -> FETCH for BEQ (pc_write=zero) and J (pc_write=1).
REQ-016 SHALL, in MEM: LW asserts mem_read=1, next WB; SW asserts mem_write=1, next FETCH.
REQ-017 SHALL, in WB, assert reg_write=1 for exactly one cycle; s_wb=1 for LW, 0 otherwise; next FETCH.
REQ-018 SHALL assert reg_write only in WB, mem_write only in MEM, ir_write only in FETCH; no default write enables.
REQ-019 SHALL, in TRAP, hold trap=1 and all enables 0 until reset (sticky).
REQ-020 SHALL drive all outputs combinationally from state and latched fields; unused selects driven 0.

Reset
REQ-021 SHALL, while rst=1, force state=FETCH, latched op/funct=0, MD counter=0, trap=0, and all write enables/md_start=0 regardless of state.
REQ-022 SHALL, on rst asserted mid-instruction (any state incl. MD_WAIT/TRAP), abandon it; first cycle after deassert is FETCH with ir_write=1.

Configuration
REQ-023 SHALL, with MULTDIV_EN defined, treat SPECIAL funct 011000 (MULT) and 011010 (DIV) as: EXEC pulses md_start=1 one cycle, next MD_WAIT.
REQ-024 SHALL, in MD_WAIT, increment an 8-bit counter each cycle; md_done=1 -> FETCH (counter cleared); counter reaching MD_TIMEOUT without md_done -> TRAP; md_done and timeout in same cycle -> FETCH.
REQ-025 SHALL, without MULTDIV_EN, omit MD_WAIT logic and counter, tie md_start=0, and route MULT/DIV funct from DECODE to TRAP.

Verification
REQ-026 SHALL cover: reset, op=000000 funct=100001 -> state 0,1,2,4,0; aluop=0001 in EXEC; reg_write=1 only in WB.
REQ-027 SHALL cover: op=100011 (LW) -> states 0,1,2,3,4; mem_read=1 in MEM; s_wb=1 and reg_write=1 in WB; op=101011 -> mem_write=1 in MEM, no WB.
REQ-028 SHALL cover: BEQ with zero=1 then zero=0 -> pc_write 1 then 0 in EXEC; op=111111 -> trap=1 from cycle after DECODE, held 10 cycles, cleared by rst.
REQ-029 SHALL cover (MULTDIV_EN): funct=011000, md_done after 5 cycles -> md_start one-cycle pulse, FETCH next; md_done never -> TRAP after MD_TIMEOUT=64 cycles.
REQ-030 SHALL cover: rst pulsed mid-MD_WAIT and mid-MEM -> all enables 0 during rst, FETCH immediately after release, no stray mem_write/reg_write.
